// File: rtl/ivs_rst_seq.sv
// ivs_rst_seq: staged reset release sequencer (bus -> core -> periph)
// in: aclk, arst, pll_lock, sw_rst_req  out: bus/core/periph_rst_n, rst_done, rst_cause
module ivs_rst_seq #(
  parameter int CNT_W      = 8,
  parameter int LOCK_FLT   = 16,
  parameter int BUS_DLY    = 4,
  parameter int CORE_DLY   = 8,
  parameter int PERIPH_DLY = 8,
  parameter int SW_HOLD    = 32
) (
  input  logic       aclk,
  input  logic       arst,
  input  logic       pll_lock,
  input  logic       sw_rst_req,
  output logic       bus_rst_n,
  output logic       core_rst_n,
  output logic       periph_rst_n,
  output logic       rst_done,
  output logic [1:0] rst_cause
);

  localparam int CNT_MAX = (2 ** CNT_W) - 1;

  // Terminal count for a delay: a delay of 0 behaves as 1,
  // and the target is capped at the saturation value.
  function automatic int last_cnt(input int dly);
    int d;
    d = (dly < 1) ? 1 : dly;
    return (d - 1 > CNT_MAX) ? CNT_MAX : d - 1;
  endfunction

  localparam logic [CNT_W-1:0] LOCK_END = CNT_W'(last_cnt(LOCK_FLT));
  localparam logic [CNT_W-1:0] BUS_END  = CNT_W'(last_cnt(BUS_DLY));
  localparam logic [CNT_W-1:0] CORE_END = CNT_W'(last_cnt(CORE_DLY));
  localparam logic [CNT_W-1:0] PER_END  = CNT_W'(last_cnt(PERIPH_DLY));
  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(last_cnt(SW_HOLD));

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    REL_BUS,
    REL_CORE,
    REL_PERIPH,
    RUN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             lock_lost;

  // Saturating increment: the counter never wraps.
  always_comb begin
    cnt_inc = cnt;
    if (!(&cnt))
      cnt_inc = cnt + CNT_W'(1);
  end

  // Lock only matters once it has been qualified.
  always_comb begin
    lock_lost = 1'b0;
    if (!pll_lock)
      lock_lost = (state == REL_BUS) || (state == REL_CORE) ||
                  (state == REL_PERIPH) || (state == RUN);
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state        <= HOLD;
      cnt          <= '0;
      bus_rst_n    <= 1'b0;
      core_rst_n   <= 1'b0;
      periph_rst_n <= 1'b0;
      rst_done     <= 1'b0;
      rst_cause    <= CAUSE_POR;
    end else if (sw_rst_req) begin
      // Software wins over a simultaneous lock loss; in HOLD
      // this restarts the minimum hold time.
      state        <= HOLD;
      cnt          <= '0;
      bus_rst_n    <= 1'b0;
      core_rst_n   <= 1'b0;
      periph_rst_n <= 1'b0;
      rst_done     <= 1'b0;
      rst_cause    <= CAUSE_SW;
    end else if (lock_lost) begin
      state        <= HOLD;
      cnt          <= '0;
      bus_rst_n    <= 1'b0;
      core_rst_n   <= 1'b0;
      periph_rst_n <= 1'b0;
      rst_done     <= 1'b0;
      rst_cause    <= CAUSE_LOCK;
    end else begin
      unique case (state)
        HOLD: begin
          // Only a software reset enforces the long hold.
          if (rst_cause == CAUSE_SW && cnt != HOLD_END) begin
            cnt <= cnt_inc;
          end else begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end
        end
        WAIT_LOCK: begin
          if (!pll_lock) begin
            cnt <= '0;
          end else if (cnt == LOCK_END) begin
            state <= REL_BUS;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        REL_BUS: begin
          if (cnt == BUS_END) begin
            bus_rst_n <= 1'b1;
            state     <= REL_CORE;
            cnt       <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        REL_CORE: begin
          if (cnt == CORE_END) begin
            core_rst_n <= 1'b1;
            state      <= REL_PERIPH;
            cnt        <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        REL_PERIPH: begin
          if (cnt == PER_END) begin
            periph_rst_n <= 1'b1;
            rst_done     <= 1'b1;
            state        <= RUN;
            cnt          <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RUN: begin
          cnt <= '0;
        end
        default: begin
          state        <= HOLD;
          cnt          <= '0;
          bus_rst_n    <= 1'b0;
          core_rst_n   <= 1'b0;
          periph_rst_n <= 1'b0;
          rst_done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
